// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM encoding, master indices and the legal LATENCY range.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // Out-of-range latencies are clamped so the counter can never wrap.
  function automatic int lat_cnt_init(input int lat);
    if (lat < LATENCY_MIN) return 0;
    if (lat > LATENCY_MAX) return LATENCY_MAX - 1;
    return lat - 1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master
// that was not granted last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt_idx = ~last_gnt;
    else              gnt_idx = req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and access sequencer for the single-port data memory.
// Serialises CPU (m0) and loader (m1) accesses and stalls the CPU while its access is pending.
//
// state | meaning
// IDLE  | sample requests, grant one, launch its memory command
// WAIT  | hold the memory command for LATENCY cycles, capture read data on the last one
// RESP  | one-cycle acknowledge to the grantee, requests ignored
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(lat_cnt_init(LATENCY));

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             gnt;
  logic             gnt_valid;
  logic             gnt_idx;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign cpu_stall = m0_req & ~m0_ack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= M_LDR;
      gnt       <= M_CPU;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            state    <= WAIT;
            gnt      <= gnt_idx;
            last_gnt <= gnt_idx;
            cnt      <= CNT_INIT;
            mem_en   <= 1'b1;
            if (gnt_idx == M_LDR) begin
              mem_we    <= m1_we;
              mem_addr  <= m1_addr;
              mem_wdata <= m1_wdata;
            end else begin
              mem_we    <= m0_we;
              mem_addr  <= m0_addr;
              mem_wdata <= m0_wdata;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Writes return zero so a stale read value never looks fresh.
            if (gnt == M_LDR) begin
              m1_rdata <= mem_we ? '0 : mem_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= mem_we ? '0 : mem_rdata;
              m0_ack   <= 1'b1;
            end
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: two instances (LATENCY 1 and 3), each checked
// cycle by cycle against a transaction-level model of grant order and access timing.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        rq  [2][2];
  logic        we  [2][2];
  logic [31:0] ad  [2][2];
  logic [31:0] wd  [2][2];
  logic        ack [2][2];
  logic [31:0] rd  [2][2];
  logic        men [2];
  logic        mwe [2];
  logic        stall [2];
  logic [31:0] mad [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];
  logic [31:0] pmem [2][64];

  assign mrd[0] = pmem[0][mad[0][7:2]];
  assign mrd[1] = pmem[1][mad[1][7:2]];

  dmem_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut_l1 (
    .clk(clk), .rstn(rstn),
    .m0_req(rq[0][0]), .m0_we(we[0][0]), .m0_addr(ad[0][0]), .m0_wdata(wd[0][0]),
    .m0_ack(ack[0][0]), .m0_rdata(rd[0][0]),
    .m1_req(rq[0][1]), .m1_we(we[0][1]), .m1_addr(ad[0][1]), .m1_wdata(wd[0][1]),
    .m1_ack(ack[0][1]), .m1_rdata(rd[0][1]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(mad[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0]), .cpu_stall(stall[0])
  );

  dmem_arbiter #(.LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_dut_l3 (
    .clk(clk), .rstn(rstn),
    .m0_req(rq[1][0]), .m0_we(we[1][0]), .m0_addr(ad[1][0]), .m0_wdata(wd[1][0]),
    .m0_ack(ack[1][0]), .m0_rdata(rd[1][0]),
    .m1_req(rq[1][1]), .m1_we(we[1][1]), .m1_addr(ad[1][1]), .m1_wdata(wd[1][1]),
    .m1_ack(ack[1][1]), .m1_rdata(rd[1][1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(mad[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1]), .cpu_stall(stall[1])
  );

  // Reference model: one in-flight access per lane, tracked by its age in cycles.
  bit          busy [2];
  int          phase [2];
  int          gm [2];
  int          lastg [2];
  logic        cwe [2];
  logic [31:0] caddr [2];
  logic [31:0] cwd [2];
  logic [31:0] exp_rd [2][2];
  logic [31:0] rstore [2][64];
  bit          prev_ack [2][2];
  bit          fv  [2][2];
  logic        fwe [2][2];
  logic [31:0] fad [2][2];
  logic [31:0] fwd [2][2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000_8000 + ($urandom_range(0, 63) << 2);
  endfunction

  task automatic issue(input int l, input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    fv[l][m]  = 1'b1;
    fwe[l][m] = w;
    fad[l][m] = a;
    fwd[l][m] = d;
  endtask

  task automatic reset_model();
    for (int l = 0; l < 2; l++) begin
      busy[l]  = 1'b0;
      phase[l] = 0;
      gm[l]    = 0;
      lastg[l] = 1;
      for (int m = 0; m < 2; m++) begin
        rq[l][m] = 1'b0; we[l][m] = 1'b0; ad[l][m] = '0; wd[l][m] = '0;
        fv[l][m] = 1'b0; prev_ack[l][m] = 1'b0; exp_rd[l][m] = '0;
      end
    end
  endtask

  task automatic chk_reset(input int l);
    chk($sformatf("L%0d rst mem_en", l), 32'(men[l]), 32'd0);
    chk($sformatf("L%0d rst mem_we", l), 32'(mwe[l]), 32'd0);
    chk($sformatf("L%0d rst mem_addr", l), mad[l], 32'd0);
    chk($sformatf("L%0d rst mem_wdata", l), mwd[l], 32'd0);
    chk($sformatf("L%0d rst m0_ack", l), 32'(ack[l][0]), 32'd0);
    chk($sformatf("L%0d rst m1_ack", l), 32'(ack[l][1]), 32'd0);
    chk($sformatf("L%0d rst m0_rdata", l), rd[l][0], 32'd0);
    chk($sformatf("L%0d rst m1_rdata", l), rd[l][1], 32'd0);
  endtask

  // One clock cycle on lane l; p0/p1 are the percent chances an idle master raises req.
  task automatic step(input int l, input int p0, input int p1);
    int L;
    bit een;
    bit ea [2];
    int pp;
    int g;
    L = lat_of(l);
    @(negedge clk);
    een = busy[l] && (phase[l] <= L);
    for (int m = 0; m < 2; m++) ea[m] = busy[l] && (phase[l] == L + 1) && (gm[l] == m);
    if (busy[l] && (phase[l] == L + 1)) begin
      if (cwe[l]) begin
        rstore[l][caddr[l][7:2]] = cwd[l];
        exp_rd[l][gm[l]] = '0;
      end else begin
        exp_rd[l][gm[l]] = rstore[l][caddr[l][7:2]];
      end
    end
    if (men[l] && mwe[l]) pmem[l][mad[l][7:2]] = mwd[l];

    chk($sformatf("L%0d mem_en", l), 32'(men[l]), 32'(een));
    chk($sformatf("L%0d mem_we", l), 32'(mwe[l]), 32'(een ? cwe[l] : 1'b0));
    chk($sformatf("L%0d mem_addr", l), mad[l], een ? caddr[l] : 32'd0);
    chk($sformatf("L%0d mem_wdata", l), mwd[l], een ? cwd[l] : 32'd0);
    chk($sformatf("L%0d m0_ack", l), 32'(ack[l][0]), 32'(ea[0]));
    chk($sformatf("L%0d m1_ack", l), 32'(ack[l][1]), 32'(ea[1]));
    chk($sformatf("L%0d m0_rdata", l), rd[l][0], exp_rd[l][0]);
    chk($sformatf("L%0d m1_rdata", l), rd[l][1], exp_rd[l][1]);

    for (int m = 0; m < 2; m++) begin
      pp = (m == 0) ? p0 : p1;
      if (!rq[l][m] || prev_ack[l][m]) begin
        if (fv[l][m]) begin
          rq[l][m] = 1'b1; we[l][m] = fwe[l][m]; ad[l][m] = fad[l][m]; wd[l][m] = fwd[l][m];
          fv[l][m] = 1'b0;
        end else if (int'($urandom_range(0, 99)) < pp) begin
          rq[l][m] = 1'b1; we[l][m] = 1'($urandom_range(0, 1));
          ad[l][m] = rnd_addr(); wd[l][m] = $urandom;
        end else begin
          rq[l][m] = 1'b0;
        end
      end
    end
    #1;
    chk($sformatf("L%0d cpu_stall", l), 32'(stall[l]), 32'(rq[l][0] && !ea[0]));

    if (!busy[l]) begin
      if (rq[l][0] || rq[l][1]) begin
        g = (rq[l][0] && rq[l][1]) ? 1 - lastg[l] : (rq[l][1] ? 1 : 0);
        busy[l] = 1'b1; phase[l] = 1; gm[l] = g; lastg[l] = g;
        cwe[l] = we[l][g]; caddr[l] = ad[l][g]; cwd[l] = wd[l][g];
      end
    end else if (phase[l] == L + 1) begin
      busy[l] = 1'b0;
    end else begin
      phase[l]++;
    end
    for (int m = 0; m < 2; m++) prev_ack[l][m] = ea[m];
  endtask

  initial begin
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 64; i++) begin
        pmem[l][i]   = $urandom;
        rstore[l][i] = pmem[l][i];
      end
    reset_model();
    #2 rstn = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rstn = 1'b1;

    // First tie after reset goes to the CPU, then the loader.
    issue(0, 0, 1'b0, rnd_addr(), 32'd0);
    issue(0, 1, 1'b0, rnd_addr(), 32'd0);
    repeat (8) step(0, 0, 0);

    // Single CPU read returning a known word.
    pmem[0][1]   = 32'hDEAD_BEEF;
    rstore[0][1] = 32'hDEAD_BEEF;
    issue(0, 0, 1'b0, 32'h1000_8004, 32'd0);
    repeat (5) step(0, 0, 0);
    chk("L0 single read rdata", rd[0][0], 32'hDEAD_BEEF);

    // Both masters streaming back-to-back, then random traffic.
    repeat (30) step(0, 100, 100);
    repeat (8) step(0, 0, 0);
    repeat (300) step(0, 35, 35);
    repeat (8) step(0, 0, 0);

    // Loader write then CPU readback at LATENCY=3.
    issue(1, 1, 1'b1, 32'h1000_8000, 32'h1234_5678);
    repeat (7) step(1, 0, 0);
    issue(1, 0, 1'b0, 32'h1000_8000, 32'd0);
    repeat (7) step(1, 0, 0);
    chk("L1 write readback", rd[1][0], 32'h1234_5678);

    // CPU request arrives while the loader is in WAIT.
    issue(1, 1, 1'b0, rnd_addr(), 32'd0);
    repeat (2) step(1, 0, 0);
    issue(1, 0, 1'b0, rnd_addr(), 32'd0);
    repeat (12) step(1, 0, 0);

    // Reset in the middle of a CPU read.
    issue(1, 0, 1'b0, rnd_addr(), 32'd0);
    repeat (2) step(1, 0, 0);
    chk("L1 mem_en before abort", 32'(men[1]), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_reset(1);
    reset_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) step(1, 0, 0);
    issue(1, 0, 1'b0, rnd_addr(), 32'd0);
    repeat (8) step(1, 0, 0);

    repeat (300) step(1, 40, 40);
    repeat (12) step(1, 0, 0);
    repeat (40) step(1, 100, 100);
    repeat (12) step(1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
